// File: rtl/div_unit_if.sv
// Request/result bundle between the EX stage and the multi-cycle divider.
// Signal names keep their legacy direction suffixes for drop-in compatibility.
interface div_unit_if #(
  parameter int N = 32
);
  logic           start_i;
  logic           signed_i;
  logic           annul_i;
  logic [N-1:0]   opdata1_i;
  logic [N-1:0]   opdata2_i;
  logic [2*N-1:0] result_o;
  logic           ready_o;
  logic           stall_o;

  modport master (
    output start_i, signed_i, annul_i, opdata1_i, opdata2_i,
    input  result_o, ready_o, stall_o
  );

  modport slave (
    input  start_i, signed_i, annul_i, opdata1_i, opdata2_i,
    output result_o, ready_o, stall_o
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU; one quotient bit per cycle.
// Result packs {remainder, quotient} to match the HI/LO write path.
module div_unit #(
  parameter int N = 32
) (
  input  logic     clk,
  input  logic     rst,
  div_unit_if.slave bus
);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BYZERO = 2'd1;
  localparam logic [1:0] BUSY   = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]     state;
  logic [CW-1:0]  cnt;
  logic [2*N:0]   work;
  logic [N-1:0]   dividend;
  logic [N-1:0]   divisor;
  logic           sign_a;
  logic           sign_b;
  logic           is_signed;
  logic [2*N-1:0] result;

  logic           req;
  logic [N-1:0]   abs_a;
  logic [N-1:0]   abs_b;
  logic [2*N:0]   shifted;
  logic [2*N:0]   work_nxt;
  logic [N-1:0]   quot;
  logic [N-1:0]   rem;
  logic [N-1:0]   quot_fix;
  logic [N-1:0]   rem_fix;

  assign req   = bus.start_i & ~bus.annul_i;
  assign abs_a = (bus.signed_i & bus.opdata1_i[N-1]) ? -bus.opdata1_i : bus.opdata1_i;
  assign abs_b = (bus.signed_i & bus.opdata2_i[N-1]) ? -bus.opdata2_i : bus.opdata2_i;

  always_comb begin
    shifted  = {work[2*N-1:0], 1'b0};
    work_nxt = shifted;
    if (shifted[2*N:N] >= {1'b0, divisor})
      work_nxt = {shifted[2*N:N] - {1'b0, divisor}, shifted[N-1:1], 1'b1};
    quot     = work_nxt[N-1:0];
    rem      = work_nxt[2*N-1:N];
    quot_fix = (is_signed & (sign_a ^ sign_b)) ? -quot : quot;
    rem_fix  = (is_signed & sign_a) ? -rem : rem;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      work      <= '0;
      dividend  <= '0;
      divisor   <= '0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      is_signed <= 1'b0;
      result    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (bus.opdata2_i == '0) begin
              // Divide-by-zero reports the raw dividend in HI, so keep it unmodified.
              dividend <= bus.opdata1_i;
              state    <= BYZERO;
            end else begin
              dividend  <= abs_a;
              divisor   <= abs_b;
              sign_a    <= bus.opdata1_i[N-1];
              sign_b    <= bus.opdata2_i[N-1];
              is_signed <= bus.signed_i;
              cnt       <= '0;
              work      <= {{(N+1){1'b0}}, abs_a};
              state     <= BUSY;
            end
          end
        end
        BYZERO: begin
          if (bus.annul_i) begin
            state <= IDLE;
          end else begin
            result <= {dividend, {N{1'b1}}};
            state  <= DONE;
          end
        end
        BUSY: begin
          if (bus.annul_i) begin
            state <= IDLE;
          end else begin
            work <= work_nxt;
            cnt  <= cnt + 1'b1;
            if (cnt == LAST) begin
              result <= {rem_fix, quot_fix};
              state  <= DONE;
            end
          end
        end
        default: begin
          if (!bus.start_i)
            state <= IDLE;
        end
      endcase
    end
  end

  assign bus.result_o = result;
  assign bus.ready_o  = (state == DONE);
  assign bus.stall_o  = req & (state != DONE);

endmodule
